adpll_pi: RTL and testbench

ADPLL_PI -- requirements
Module: adpll_pi

---
 rtl/adpll_pi.sv | 154 +++++++++++++++
 tb/tb_adpll_pi.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/adpll_pi.sv
// adpll_pi: all-digital PLL core with a PI loop filter.
// An NCO phase accumulator is phase-compared against a synchronised reference
// edge; the error drives a proportional + integral correction of the FCW.
// Optional feature macro: ADPLL_HOLDOVER_EN (reference-loss timeout/holdover).
module adpll_pi #(
    parameter int              ACC_W    = 24,
    parameter int              ERR_W    = 12,
    parameter logic [ACC_W-1:0] FCW_INIT = 24'h010000,
    parameter logic [ACC_W-1:0] FCW_MIN  = 24'h008000,
    parameter logic [ACC_W-1:0] FCW_MAX  = 24'h018000,
    parameter int              KP_SH    = 2,
    parameter int              KI_SH    = 6,
    parameter int              LOCK_TOL = 16,
    parameter int              LOCK_CNT = 16,
    parameter int              REF_TMO  = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rf,
    input  logic             i_en,
    output logic             o_gen,
    output logic             o_lock,
    output logic [ACC_W-1:0] o_fcw,
    output logic             o_holdover
);

    // two guard bits so the unclipped FCW can be compared without overflow
    localparam int XW  = ACC_W + 2;
    localparam int LCW = $clog2(LOCK_CNT + 1);
    localparam logic signed [XW-1:0] INIT_X = {2'b00, FCW_INIT};
    localparam logic signed [XW-1:0] MIN_X  = {2'b00, FCW_MIN};
    localparam logic signed [XW-1:0] MAX_X  = {2'b00, FCW_MAX};
    localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_CNT);
    localparam logic [ERR_W-1:0] TOL      = ERR_W'(LOCK_TOL);

    logic [2:0]              rf_sync;
    logic                    ref_tick;
    logic                    upd;
    logic [ACC_W-1:0]        acc;
    logic signed [ACC_W-1:0] integ;
    logic signed [ERR_W-1:0] err, p_term, i_term;
    logic [ERR_W-1:0]        err_mag;
    logic signed [XW-1:0]    integ_nx, fcw_raw;
    logic [ACC_W-1:0]        fcw_sat;
    logic                    clip;
    logic                    in_tol;
    logic [LCW-1:0]          lock_cnt;
    logic                    hold_set;

    // rf_sync[1:0] is the synchroniser, rf_sync[2] the edge-detect history
    assign ref_tick = rf_sync[1] & ~rf_sync[2];
    assign upd      = i_en & ref_tick;

    // accumulator top bits with MSB flipped: zero when o_gen is just rising
    assign err     = {~acc[ACC_W-1], acc[ACC_W-2 -: ERR_W-1]};
    assign p_term  = err >>> KP_SH;
    assign i_term  = err >>> KI_SH;
    assign err_mag = err[ERR_W-1] ? -err : err;   // unsigned, so -2^(ERR_W-1) maps to 2^(ERR_W-1)
    assign in_tol  = err_mag < TOL;

    assign integ_nx = XW'(integ) + XW'(i_term);
    assign fcw_raw  = INIT_X - (integ_nx + XW'(p_term));
    assign o_gen    = acc[ACC_W-1];

    // clip the new FCW; flag it so the integrator can hold (anti-windup)
    always_comb begin
        fcw_sat = fcw_raw[ACC_W-1:0];
        clip    = 1'b0;
        if (fcw_raw < MIN_X) begin
            fcw_sat = FCW_MIN;
            clip    = 1'b1;
        end else if (fcw_raw > MAX_X) begin
            fcw_sat = FCW_MAX;
            clip    = 1'b1;
        end
    end

    // reference synchroniser and edge history
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rf_sync <= '0;
        else          rf_sync <= {rf_sync[1:0], i_rf};
    end

    // NCO phase accumulator, free-running while enabled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  acc <= '0;
        else if (!i_en) acc <= '0;
        else           acc <= acc + o_fcw;
    end

    // PI loop filter: update integrator and FCW once per reference edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            integ <= '0;
            o_fcw <= FCW_INIT;
        end else if (!i_en) begin
            integ <= '0;
            o_fcw <= FCW_INIT;
        end else if (upd) begin
            if (!clip) integ <= integ_nx[ACC_W-1:0];
            o_fcw <= fcw_sat;
        end
    end

    // lock detector: consecutive in-tolerance edges, any miss clears it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_cnt <= '0;
            o_lock   <= 1'b0;
        end else if (!i_en) begin
            lock_cnt <= '0;
            o_lock   <= 1'b0;
        end else if (upd) begin
            if (in_tol) begin
                if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + LCW'(1);
                o_lock <= (lock_cnt >= LOCK_MAX - LCW'(1));
            end else begin
                lock_cnt <= '0;
                o_lock   <= 1'b0;
            end
        end else if (hold_set) begin
            lock_cnt <= '0;
            o_lock   <= 1'b0;
        end
    end

`ifdef ADPLL_HOLDOVER_EN
    localparam int TCW = $clog2(REF_TMO + 1);
    logic [TCW-1:0] tmo_cnt;

    // fires on the cycle the timeout counter reaches REF_TMO
    assign hold_set = i_en & ~ref_tick & (tmo_cnt == TCW'(REF_TMO - 1));

    // cycles since the last reference edge; saturates at the timeout
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt    <= '0;
            o_holdover <= 1'b0;
        end else if (!i_en || ref_tick) begin
            tmo_cnt    <= '0;
            o_holdover <= 1'b0;
        end else begin
            if (tmo_cnt != TCW'(REF_TMO)) tmo_cnt <= tmo_cnt + TCW'(1);
            if (hold_set) o_holdover <= 1'b1;
        end
    end
`else
    // timeout length only matters when holdover is built in
    localparam int unused_ref_tmo = REF_TMO;
    assign hold_set   = 1'b0;
    assign o_holdover = 1'b0;
`endif

endmodule

// File: tb/tb_adpll_pi.sv
// Directed bench for adpll_pi. Reference edges are placed on exact cycles so
// the phase error at each tick, and hence the FCW response, is hand-computable.
// A second instance with narrow FCW bounds exercises clipping and anti-windup.
module tb_adpll_pi;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_rf = 1'b0;
    logic        i_en = 1'b0;
    logic        gen, lock, hold;
    logic [23:0] fcw;
    logic        gen2, lock2, hold2;
    logic [23:0] fcw2;

    int nt = 0;
    int nf = 0;
    int cyc = 0;
    int rf_ph = 0;
    int rf_per = 256;
    bit rf_on = 1'b0;

    adpll_pi dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rf(i_rf), .i_en(i_en),
        .o_gen(gen), .o_lock(lock), .o_fcw(fcw), .o_holdover(hold)
    );

    adpll_pi #(.FCW_MIN(24'h00FEF3), .FCW_MAX(24'h01010D)) dut_sat (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rf(i_rf), .i_en(i_en),
        .o_gen(gen2), .o_lock(lock2), .o_fcw(fcw2), .o_holdover(hold2)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          off;     // tick phase offset in cycles from o_gen rising
        logic [23:0] f1;      // FCW after first tick, wide bounds
        logic [23:0] f1s;     // FCW after first tick, narrow bounds
        bit          two;     // also check the second tick
        logic [23:0] f2;
        logic [23:0] f2s;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nt++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive_rf();
        if (rf_on) begin
            if (rf_ph < 0) i_rf = 1'b0;
            else           i_rf = ((rf_ph % rf_per) < rf_per / 2);
            rf_ph++;
        end
    endtask

    // each step: one rising edge happened, now at the following falling edge
    task automatic step(input int n);
        repeat (n) begin
            @(negedge i_clk);
            cyc++;
            drive_rf();
        end
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0; i_en = 1'b0; rf_on = 1'b0; i_rf = 1'b0;
        step(2);
        i_rst_n = 1'b1;
        step(2);
    endtask

    // enable with acc=0; first i_rf rise lands just before edge d
    task automatic start_run(input int d);
        i_en = 1'b1; rf_on = 1'b1; rf_ph = 1 - d; cyc = 0;
        drive_rf();
    endtask

    initial begin
        int d, r1, r2;
        logic pg;
        vecs[0] = '{0,    24'h010000, 24'h010000, 1'b1, 24'h010000, 24'h010000};
        vecs[1] = '{1,    24'h00FFFC, 24'h00FFFC, 1'b1, 24'h00FFFD, 24'h00FFFD};
        vecs[2] = '{-1,   24'h010005, 24'h010005, 1'b0, 24'h0,      24'h0};
        vecs[3] = '{4,    24'h00FFEF, 24'h00FFEF, 1'b0, 24'h0,      24'h0};
        vecs[4] = '{64,   24'h00FEF0, 24'h00FEF3, 1'b1, 24'h00FEE6, 24'h00FEF6};
        vecs[5] = '{-64,  24'h010110, 24'h01010D, 1'b1, 24'h01011C, 24'h01010C};
        vecs[6] = '{-128, 24'h010220, 24'h01010D, 1'b0, 24'h0,      24'h0};
        vecs[7] = '{127,  24'h00FDE5, 24'h00FEF3, 1'b0, 24'h0,      24'h0};

        // reset with enable high and a toggling reference
        i_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            i_rf = ~i_rf;
        end
        chk("rst_gen",  {31'd0, gen},  0);
        chk("rst_lock", {31'd0, lock}, 0);
        chk("rst_fcw",  {8'd0, fcw},   32'h010000);
        chk("rst_hold", {31'd0, hold}, 0);
        chk("rst_fcw2", {8'd0, fcw2},  32'h010000);

        // single/double tick responses at known phase offsets
        foreach (vecs[i]) begin
            do_reset();
            d = 127 + vecs[i].off;
            if (d < 1) d += 256;
            start_run(d);
            step(d + 1);
            chk($sformatf("pre_fcw[%0d]", i), {8'd0, fcw}, 32'h010000);
            step(1);
            chk($sformatf("t1_fcw[%0d]", i),  {8'd0, fcw},  {8'd0, vecs[i].f1});
            chk($sformatf("t1_fcws[%0d]", i), {8'd0, fcw2}, {8'd0, vecs[i].f1s});
            chk($sformatf("t1_lock[%0d]", i), {31'd0, lock}, 0);
            if (vecs[i].two) begin
                step(256);
                chk($sformatf("t2_fcw[%0d]", i),  {8'd0, fcw},  {8'd0, vecs[i].f2});
                chk($sformatf("t2_fcws[%0d]", i), {8'd0, fcw2}, {8'd0, vecs[i].f2s});
            end
        end

        // in-phase lock: ticks at 129+256m, 16th tick at edge 3969
        do_reset();
        start_run(127);
        step(3968);
        chk("lock_pre", {31'd0, lock}, 0);
        step(1);
        chk("lock_on",  {31'd0, lock}, 1);
        chk("lock_fcw", {8'd0, fcw}, 32'h010000);
        // pull the next reference rise 128 cycles early: tick sees acc=0, e=-2048
        rf_ph -= 128;
        step(127);
        chk("jump_pre", {31'd0, lock}, 1);
        step(1);
        chk("jump_lock", {31'd0, lock}, 0);
        chk("jump_fcw",  {8'd0, fcw},  32'h010220);
        chk("jump_fcws", {8'd0, fcw2}, 32'h01010D);

        // one-cycle disable clears everything
        rf_on = 1'b0; i_rf = 1'b0; i_en = 1'b0;
        step(1);
        chk("dis_lock", {31'd0, lock}, 0);
        chk("dis_fcw",  {8'd0, fcw},   32'h010000);
        chk("dis_gen",  {31'd0, gen},  0);
        chk("dis_hold", {31'd0, hold}, 0);

        // relock and check generated period
        start_run(127);
        step(3968);
        chk("relock_pre", {31'd0, lock}, 0);
        step(1);
        chk("relock_on", {31'd0, lock}, 1);
        r1 = 0; r2 = 0;
        for (int k = 0; k < 512; k++) begin
            pg = gen;
            step(1);
            if (!pg && gen) begin
                if (r1 == 0) r1 = cyc;
                else         r2 = cyc;
            end
        end
        chk("gen_period", r2 - r1, 256);

        // reference stops right after the tick at edge 4481
        rf_on = 1'b0; i_rf = 1'b0;
`ifdef ADPLL_HOLDOVER_EN
        step(1023);
        chk("ho_pre",  {31'd0, hold}, 0);
        step(1);
        chk("ho_set",  {31'd0, hold}, 1);
        chk("ho_lock", {31'd0, lock}, 0);
        chk("ho_fcw",  {8'd0, fcw},   32'h010000);
        rf_on = 1'b1; rf_ph = 0;
        step(3);
        chk("ho_wait", {31'd0, hold}, 1);
        step(1);
        chk("ho_clr",  {31'd0, hold}, 0);
`else
        step(1024);
        chk("noho_hold", {31'd0, hold}, 0);
        chk("noho_fcw",  {8'd0, fcw},   32'h010000);
        chk("noho_lock", {31'd0, lock}, 1);
`endif

        // asynchronous reset between clock edges
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_lock", {31'd0, lock}, 0);
        chk("arst_gen",  {31'd0, gen},  0);
        chk("arst_fcw",  {8'd0, fcw},   32'h010000);
        // i_rf already high at release: first tick only on the 3rd edge
        rf_on = 1'b0; i_rf = 1'b1;
        @(negedge i_clk);
        i_rst_n = 1'b1; i_en = 1'b1; cyc = 0;
        step(2);
        chk("rel_pre", {8'd0, fcw}, 32'h010000);
        step(1);
        chk("rel_fcw",  {8'd0, fcw},  32'h010218);
        chk("rel_fcws", {8'd0, fcw2}, 32'h01010D);

        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule
